// File: rtl/multi_ss_adc_ctrl_if.sv
// Result-frame handshake between the single-slope ADC controller and its consumer.
// The master side (controller) drives valid/data/ovf; the consumer drives ready.
interface multi_ss_adc_ctrl_if #(
    parameter int NUM_SENSORS = 1,
    parameter int WIDTH       = 8
);
    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_SENSORS*WIDTH-1:0] out_data;
    logic [NUM_SENSORS-1:0]       out_ovf;

    modport master (output out_valid, output out_data, output out_ovf, input out_ready);
    modport slave  (input out_valid, input out_data, input out_ovf, output out_ready);
endinterface

// File: rtl/multi_ss_adc_ctrl.sv
// Multi-channel single-slope ADC back-end: ramp sequencing, comparator synchronisation,
// first-edge time capture per channel and a packed result frame on a valid/ready handshake.

module multi_ss_adc_lane #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             comp_i,
    input  logic             clr_i,
    input  logic             arm_i,
    input  logic [WIDTH+1:0] t_i,
    output logic             cap_d_o,
    output logic [WIDTH-1:0] val_d_o
);
    localparam int SW = (SYNC_STAGES > 0) ? SYNC_STAGES : 1;
    localparam logic [WIDTH+1:0] SOFF = (WIDTH+2)'(SYNC_STAGES);

    logic [SW-1:0]    sync_q;
    logic             comp_s, prev_q, cap_q, hit;
    logic [WIDTH-1:0] val_q, t_cap;
    logic [WIDTH+1:0] diff;

    if (SW == 1) begin : g_sync1
        always_ff @(posedge clk) begin
            if (rst) sync_q <= '0;
            else     sync_q <= comp_i;
        end
    end else begin : g_syncn
        always_ff @(posedge clk) begin
            if (rst) sync_q <= '0;
            else     sync_q <= {sync_q[SW-2:0], comp_i};
        end
    end

    assign comp_s = (SYNC_STAGES == 0) ? comp_i : sync_q[SW-1];

    // Timer runs SYNC_STAGES ahead of the sample that produced the edge; undo that skew.
    assign diff  = t_i - SOFF;
    assign t_cap = (t_i < SOFF) ? '0 :
                   (diff[WIDTH+1:WIDTH] != 2'b00) ? '1 : diff[WIDTH-1:0];

    assign hit     = arm_i & comp_s & ~prev_q & ~cap_q;
    assign cap_d_o = clr_i ? 1'b0 : (cap_q | hit);
    assign val_d_o = hit ? t_cap : val_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            cap_q  <= 1'b0;
            val_q  <= '0;
        end else begin
            prev_q <= clr_i ? 1'b0 : comp_s;
            cap_q  <= cap_d_o;
            val_q  <= val_d_o;
        end
    end
endmodule

module multi_ss_adc_ctrl #(
    parameter int NUM_SENSORS = 1,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [NUM_SENSORS-1:0] comp_out_i,
    output logic                   ramp_en_o,
    output logic [WIDTH-1:0]       ramp_code_o,
    output logic                   busy_o,
    multi_ss_adc_ctrl_if.master    res_if
);
    localparam int TW = WIDTH + 2;
    localparam logic [TW-1:0] T_LAST      = TW'((1 << WIDTH) - 1);
    localparam logic [TW-1:0] T_DRAIN_END = TW'((1 << WIDTH) + SYNC_STAGES - 1);

    typedef enum logic [1:0] {IDLE, RAMP, DRAIN, DONE} state_t;

    state_t                            state_q;
    logic [TW-1:0]                     t_q;
    logic                              ramp_en_q, busy_q, valid_q;
    logic [WIDTH-1:0]                  ramp_code_q;
    logic [NUM_SENSORS-1:0][WIDTH-1:0] data_q, val_d;
    logic [NUM_SENSORS-1:0]            ovf_q, cap_d;
    logic                              clr, arm, enter_done;

    assign clr        = (state_q == IDLE) && start_i;
    assign arm        = (state_q == RAMP) || (state_q == DRAIN);
    assign enter_done = ((state_q == RAMP) && (t_q == T_LAST) && (SYNC_STAGES == 0)) ||
                        ((state_q == DRAIN) && (t_q == T_DRAIN_END));

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_lane
        multi_ss_adc_lane #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .comp_i (comp_out_i[i]),
            .clr_i  (clr),
            .arm_i  (arm),
            .t_i    (t_q),
            .cap_d_o(cap_d[i]),
            .val_d_o(val_d[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            t_q         <= '0;
            ramp_en_q   <= 1'b0;
            ramp_code_q <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            ovf_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q     <= RAMP;
                    t_q         <= '0;
                    ramp_en_q   <= 1'b1;
                    ramp_code_q <= '0;
                    busy_q      <= 1'b1;
                end
                RAMP: begin
                    t_q <= t_q + 1'b1;
                    if (t_q == T_LAST) begin
                        ramp_en_q   <= 1'b0;
                        ramp_code_q <= '0;
                        if (SYNC_STAGES != 0) state_q <= DRAIN;
                    end else begin
                        ramp_code_q <= t_q[WIDTH-1:0] + 1'b1;
                    end
                end
                DRAIN: t_q <= t_q + 1'b1;
                DONE: if (res_if.out_ready) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            // Frame latch includes an edge captured on this very cycle.
            if (enter_done) begin
                state_q <= DONE;
                valid_q <= 1'b1;
                for (int i = 0; i < NUM_SENSORS; i++) begin
                    data_q[i] <= cap_d[i] ? val_d[i] : '1;
                    ovf_q[i]  <= ~cap_d[i];
                end
            end
        end
    end

    assign ramp_en_o        = ramp_en_q;
    assign ramp_code_o      = ramp_code_q;
    assign busy_o           = busy_q;
    assign res_if.out_valid = valid_q;
    assign res_if.out_data  = data_q;
    assign res_if.out_ovf   = ovf_q;
endmodule

// File: tb/tb_multi_ss_adc_ctrl.sv
// Bench: two controllers (SYNC_STAGES=2 and 0) share stimulus; each is checked every cycle
// against a history-based model of the first-edge timing rules, plus directed literal checks.
`timescale 1ns/1ps
module tb_multi_ss_adc_ctrl;
    localparam int N     = 2;
    localparam int W     = 4;
    localparam int S     = 2;
    localparam int CODES = 1 << W;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         ready = 1'b1;
    logic [N-1:0] comp  = '0;
    logic [N-1:0] wave [0:CODES+2*S-1];
    int           errors = 0;
    int           checks = 0;
    bit           rst_seen = 1'b0;

    logic [1:0]          ren_a, busy_a, valid_a;
    logic [1:0][W-1:0]   code_a;
    logic [1:0][N*W-1:0] data_a;
    logic [1:0][N-1:0]   ovf_a;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int GS = (g == 0) ? S : 0;
        logic         ren, busy;
        logic [W-1:0] code;

        multi_ss_adc_ctrl_if #(.NUM_SENSORS(N), .WIDTH(W)) res_if ();
        multi_ss_adc_ctrl #(.NUM_SENSORS(N), .WIDTH(W), .SYNC_STAGES(GS)) dut (
            .clk        (clk),
            .rst        (rst),
            .start_i    (start),
            .comp_out_i (comp),
            .ramp_en_o  (ren),
            .ramp_code_o(code),
            .busy_o     (busy),
            .res_if     (res_if)
        );
        assign res_if.out_ready = ready;
        assign ren_a[g]   = ren;
        assign busy_a[g]  = busy;
        assign code_a[g]  = code;
        assign valid_a[g] = res_if.out_valid;
        assign data_a[g]  = res_if.out_data;
        assign ovf_a[g]   = res_if.out_ovf;

        // Model: hist holds what each clock edge sampled on comp (0 under reset);
        // x(k) is the sample taken at the edge where the timer read k.
        logic [N-1:0]   hist [$];
        int             base, m_n;
        bit             m_busy, m_valid;
        logic [N*W-1:0] m_data;
        logic [N-1:0]   m_ovf;

        function automatic logic [N-1:0] xs(input int k);
            int idx;
            idx = base + 1 + k;
            return (idx >= 0 && idx < hist.size()) ? hist[idx] : '0;
        endfunction

        always @(posedge clk) begin
            if (rst) begin
                hist.push_back('0);
                m_busy = 1'b0; m_valid = 1'b0; m_n = 0; m_data = '0; m_ovf = '0;
            end else begin
                hist.push_back(comp);
                if (!m_busy) begin
                    if (start) begin m_busy = 1'b1; m_n = 0; base = hist.size() - 1; end
                end else if (m_valid) begin
                    if (ready) begin m_valid = 1'b0; m_busy = 1'b0; end
                end else if (m_n + 1 == CODES + GS) begin
                    m_valid = 1'b1;
                    for (int ch = 0; ch < N; ch++) begin
                        int val;
                        logic [N-1:0] cur, prv;
                        val = -1;
                        for (int k = -GS; k < CODES; k++) begin
                            cur = xs(k);
                            prv = (k == -GS) ? '0 : xs(k - 1);
                            if (val < 0 && cur[ch] && !prv[ch]) val = (k < 0) ? 0 : k;
                        end
                        m_data[ch*W +: W] = W'((val < 0) ? CODES - 1 : val);
                        m_ovf[ch]         = (val < 0);
                    end
                end else begin
                    m_n++;
                end
            end
        end

        always @(negedge clk) if (rst_seen) begin
            chk($sformatf("dut%0d.ramp_en", g), 32'(ren), 32'(m_busy && !m_valid && m_n < CODES));
            chk($sformatf("dut%0d.ramp_code", g), 32'(code),
                (m_busy && !m_valid && m_n < CODES) ? 32'(m_n) : 32'd0);
            chk($sformatf("dut%0d.busy", g), 32'(busy), 32'(m_busy));
            chk($sformatf("dut%0d.out_valid", g), 32'(res_if.out_valid), 32'(m_valid));
            chk($sformatf("dut%0d.out_data", g), 32'(res_if.out_data), 32'(m_data));
            chk($sformatf("dut%0d.out_ovf", g), 32'(res_if.out_ovf), 32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wave_clear();
        for (int i = 0; i < CODES + 2*S; i++) wave[i] = '0;
    endtask

    task automatic wave_step(input int ch, input int k);
        for (int i = -S; i < CODES + S; i++) wave[i+S][ch] = (i >= k);
    endtask

    // Plays wave so that the edge where t=i samples wave[i+S]; start sampled at i=-1.
    // Latency counts cycles from the start cycle to the first cycle out_valid is seen.
    task automatic convert(input int extra_start, input int abort_at, output int lat0, output int lat1);
        int cur;
        lat0 = -1; lat1 = -1;
        for (int i = -S; i < CODES + S; i++) begin
            comp  = wave[i+S];
            start = (i == -1) || (i == extra_start);
            rst   = (i == abort_at);
            tick();
            if (valid_a[1] && lat1 < 0) lat1 = i + 2;
            if (valid_a[0] && lat0 < 0) lat0 = i + 2;
            if (i == abort_at) begin
                rst = 1'b0; start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        cur = CODES + S;
        while (!valid_a[0] && cur < CODES + S + 40) begin tick(); cur++; end
        if (lat0 < 0 && valid_a[0]) lat0 = cur + 1;
        chk("dut0 frame arrives", 32'(valid_a[0]), 32'd1);
    endtask

    initial begin
        int l0, l1;
        logic [N*W-1:0] held;
        wave_clear();
        rst = 1'b1; idle(3); rst_seen = 1'b1;
        rst = 1'b0; idle(4);

        // Reset mid-idle
        rst = 1'b1; idle(3);
        chk("rst out_valid", 32'(valid_a[0]), 32'd0);
        chk("rst busy", 32'(busy_a[0]), 32'd0);
        chk("rst ramp_en", 32'(ren_a[0]), 32'd0);
        chk("rst out_data", 32'(data_a[0]), 32'd0);
        rst = 1'b0; idle(5);
        chk("idle out_ovf", 32'(ovf_a[0]), 32'd0);
        chk("idle ramp_code", 32'(code_a[0]), 32'd0);

        // Two channels, distinct trip times
        wave_clear(); wave_step(0, 5); wave_step(1, 9);
        convert(-100, -100, l0, l1);
        chk("t2 latency", 32'(l0), 32'd19);
        chk("t2 out_data", 32'(data_a[0]), 32'({4'd9, 4'd5}));
        chk("t2 out_ovf", 32'(ovf_a[0]), 32'd0);
        idle(2);

        // Last code trip and a channel that never trips
        wave_clear(); wave_step(0, 15);
        convert(-100, -100, l0, l1);
        chk("t3 out_data", 32'(data_a[0]), 32'({4'd15, 4'd15}));
        chk("t3 out_ovf", 32'(ovf_a[0]), 32'({1'b1, 1'b0}));
        idle(2);

        // Comparator high before start; pulse then re-trip on ch1
        wave_clear(); wave_step(0, -S);
        for (int i = -S; i < CODES + S; i++) wave[i+S][1] = (i == 3) || (i >= 8);
        convert(-100, -100, l0, l1);
        chk("t4 out_data", 32'(data_a[0]), 32'({4'd3, 4'd0}));
        chk("t4 out_ovf", 32'(ovf_a[0]), 32'd0);
        idle(2);

        // Back-pressure with an ignored start
        wave_clear(); wave_step(0, 6); wave_step(1, 11);
        ready = 1'b0;
        convert(-100, -100, l0, l1);
        held = data_a[0];
        chk("t5 out_data", 32'(held), 32'({4'd11, 4'd6}));
        for (int j = 0; j < 10; j++) begin
            start = (j == 4);
            tick();
            chk("t5 hold valid", 32'(valid_a[0]), 32'd1);
            chk("t5 hold data", 32'(data_a[0]), 32'(held));
        end
        start = 1'b0; ready = 1'b1;
        tick();
        chk("t5 valid drop", 32'(valid_a[0]), 32'd0);
        chk("t5 busy drop", 32'(busy_a[0]), 32'd0);
        idle(2);

        // Reset in the middle of the ramp, then a clean conversion
        wave_clear(); wave_step(0, 2);
        convert(-100, 7, l0, l1);
        chk("t6 abort valid", 32'(valid_a[0]), 32'd0);
        chk("t6 abort ramp_en", 32'(ren_a[0]), 32'd0);
        chk("t6 abort busy", 32'(busy_a[0]), 32'd0);
        idle(3);
        convert(-100, -100, l0, l1);
        chk("t6 ch0", 32'(data_a[0][W-1:0]), 32'd2);
        idle(2);

        // Trip at t=0; the unsynchronised build reaches DONE two cycles earlier
        wave_clear(); wave_step(0, 0);
        convert(-100, -100, l0, l1);
        chk("t7 s0 latency", 32'(l1), 32'd17);
        chk("t7 s0 ch0", 32'(data_a[1][W-1:0]), 32'd0);
        chk("t7 s0 ovf", 32'(ovf_a[1]), 32'({1'b1, 1'b0}));
        idle(2);

        // Randomised conversions
        for (int r = 0; r < 30; r++) begin
            wave_clear();
            for (int ch = 0; ch < N; ch++) begin
                case ($urandom_range(0, 2))
                    0: wave_step(ch, int'($urandom_range(0, CODES + 2*S + 1)) - S);
                    1: for (int i = 0; i < CODES + 2*S; i++) wave[i][ch] = ($urandom_range(0, 5) == 0);
                    default: ;
                endcase
            end
            ready = $urandom_range(0, 1) != 0;
            convert(($urandom_range(0, 1) != 0) ? int'($urandom_range(0, CODES - 1)) : -100, -100, l0, l1);
            if (!ready) begin
                idle($urandom_range(0, 4));
                ready = 1'b1;
                tick();
            end
            idle($urandom_range(1, 3));
        end

        idle(30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
